gctr_block_sched: RTL and testbench

Sequencer that runs a GCTR encryption over a multi-block message using one shared AES block-cipher core. It takes 128-bit data blocks from an input stream and issues counter blocks to the core. Each keystream block it gets back is XORed with the matching data block, and the result goes to an output stream. It sits between the GCM top level (which supplies ICB, block count and message data) and a single AES core, in place of N parallel GCTR instances.

---
 rtl/gctr_pkg.sv | 38 +++
 rtl/gctr_tail_mask.sv | 21 ++
 rtl/gctr_block_sched.sv | 168 ++++++++++++++++
 tb/tb_gctr_block_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gctr_pkg.sv
// Shared definitions for the GCTR block scheduler and the GHASH/GCM controllers:
// FSM state encoding, block width, counter increment and final-block byte masking.
package gctr_pkg;

  localparam int BLOCK_WIDTH = 128;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_EMIT = 3'd4,
    ST_FIN  = 3'd5
  } gctr_state_e;

  // Increment the low 32-bit word modulo 2^32; the upper 96 bits never see a carry.
  function automatic logic [BLOCK_WIDTH-1:0] inc32(input logic [BLOCK_WIDTH-1:0] cb);
    logic [31:0] lo;
    lo = cb[31:0] + 32'd1;
    return {cb[BLOCK_WIDTH-1:32], lo};
  endfunction

  // Zero bytes nbytes..15 of a block (byte 0 is the MSB byte); nbytes==0 keeps all 16.
  function automatic logic [BLOCK_WIDTH-1:0] mask_tail(input logic [BLOCK_WIDTH-1:0] blk,
                                                       input logic [3:0]             nbytes);
    logic [BLOCK_WIDTH-1:0] r;
    r = blk;
    if (nbytes != 4'd0) begin
      for (int i = 0; i < BLOCK_WIDTH / 8; i++) begin
        if (i >= int'(nbytes)) begin
          r[BLOCK_WIDTH-1-8*i -: 8] = 8'h00;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gctr_tail_mask.sv
// Combine a data block with its keystream and, on the final block of a message,
// clear the bytes beyond the valid tail length.
module gctr_tail_mask
  import gctr_pkg::*;
(
  input  logic [BLOCK_WIDTH-1:0] i_data,
  input  logic [BLOCK_WIDTH-1:0] i_keystream,
  input  logic [3:0]             i_last_bytes,
  input  logic                   i_is_last,
  output logic [BLOCK_WIDTH-1:0] o_result
);

  logic [BLOCK_WIDTH-1:0] w_xor;
  logic [3:0]             w_nbytes;

  assign w_xor    = i_data ^ i_keystream;
  // Non-final blocks are always full, so they are passed through unmasked.
  assign w_nbytes = i_is_last ? i_last_bytes : 4'd0;
  assign o_result = mask_tail(w_xor, w_nbytes);

endmodule

// File: rtl/gctr_block_sched.sv
// GCTR sequencer: streams data blocks through one shared AES core, one counter
// block at a time, and emits data ^ E(K, CB) on the output stream.
//
// state | meaning
// IDLE  | waiting for start; configuration latched on start
// LOAD  | accepting the next data block (in_ready=1)
// REQ   | presenting the counter block to the core (aes_req_valid=1)
// WAIT  | waiting for the single-cycle keystream pulse
// EMIT  | presenting the result block (out_valid=1) until accepted
// FIN   | one-cycle done pulse, then back to IDLE
module gctr_block_sched #(
  parameter int CNT_WIDTH   = 16,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BLOCK_WIDTH-1:0] icb_in,
  input  logic [CNT_WIDTH-1:0]   num_blocks,
  input  logic [3:0]             last_bytes,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLOCK_WIDTH-1:0] in_data,
  output logic                   aes_req_valid,
  input  logic                   aes_req_ready,
  output logic [BLOCK_WIDTH-1:0] aes_req_block,
  input  logic                   aes_resp_valid,
  input  logic [BLOCK_WIDTH-1:0] aes_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLOCK_WIDTH-1:0] out_data,
  output logic                   out_last
);

  import gctr_pkg::*;

  gctr_state_e            r_state;
  logic [BLOCK_WIDTH-1:0] r_cb;
  logic [BLOCK_WIDTH-1:0] r_data;
  logic [BLOCK_WIDTH-1:0] r_out_data;
  logic [CNT_WIDTH-1:0]   r_remaining;
  logic [3:0]             r_tail;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_in_ready;
  logic                   r_req_valid;
  logic                   r_out_valid;
  logic                   r_out_last;

  logic                   w_is_last;
  logic [BLOCK_WIDTH-1:0] w_result;

  assign w_is_last = (r_remaining == CNT_WIDTH'(1));

  gctr_tail_mask u_tail_mask (
    .i_data       (r_data),
    .i_keystream  (aes_resp_data),
    .i_last_bytes (r_tail),
    .i_is_last    (w_is_last),
    .o_result     (w_result)
  );

  // Message sequencing with all handshake outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cb        <= '0;
      r_data      <= '0;
      r_out_data  <= '0;
      r_remaining <= '0;
      r_tail      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_req_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cb        <= icb_in;
            r_remaining <= num_blocks;
            r_tail      <= last_bytes;
            r_busy      <= 1'b1;
            if (num_blocks == '0) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (in_valid) begin
            r_data      <= in_data;
            r_in_ready  <= 1'b0;
            r_req_valid <= 1'b1;
            r_state     <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (aes_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (aes_resp_valid) begin
            r_out_data  <= w_result;
            r_out_last  <= w_is_last;
            r_out_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_remaining <= r_remaining - CNT_WIDTH'(1);
            r_cb        <= inc32(r_cb);
            if (w_is_last) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_in_ready <= 1'b1;
              r_state    <= ST_LOAD;
            end
          end
        end

        ST_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_req_valid <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign in_ready      = r_in_ready;
  assign aes_req_valid = r_req_valid;
  // The counter only advances in EMIT, so it is stable for the whole request.
  assign aes_req_block = r_cb;
  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_last      = r_out_last;

endmodule

// File: tb/tb_gctr_block_sched.sv
// Scoreboard bench for gctr_block_sched: randomized partners around the DUT,
// expected requests/results queued at start, monitors compare on handshakes.
module tb_gctr_block_sched;

  localparam int CW = 16;
  localparam int BW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] icb_in = '0;
  logic [CW-1:0] num_blocks = '0;
  logic [3:0]    last_bytes = '0;
  logic          busy, done;
  logic          in_valid, in_ready;
  logic [BW-1:0] in_data;
  logic          aes_req_valid, aes_req_ready;
  logic [BW-1:0] aes_req_block;
  logic          aes_resp_valid;
  logic [BW-1:0] aes_resp_data;
  logic          out_valid, out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;

  gctr_block_sched #(.CNT_WIDTH(CW), .BLOCK_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .icb_in(icb_in), .num_blocks(num_blocks),
    .last_bytes(last_bytes), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .aes_req_valid(aes_req_valid), .aes_req_ready(aes_req_ready), .aes_req_block(aes_req_block),
    .aes_resp_valid(aes_resp_valid), .aes_resp_data(aes_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Environment knobs
  bit            bp = 1'b0;
  int            resp_delay_cfg = 0;   // -1: random 0..7
  bit            ks_mode = 1'b0;       // 1: constant keystream
  logic [BW-1:0] ks_const = '0;
  bit            data_mode = 1'b0;     // 1: constant data
  logic [BW-1:0] data_const = '0;

  // Scoreboard queues
  logic [BW-1:0] in_q[$];
  logic [BW-1:0] exp_req_q[$];
  logic [BW-1:0] exp_out_q[$];
  bit            exp_last_q[$];

  // Monitor/partner state
  bit            in_fire = 1'b0;
  bit            core_pend = 1'b0;
  int            core_dly = 0;
  logic [BW-1:0] core_blk = '0;
  bit            req_pend = 1'b0;
  logic [BW-1:0] rq_blk = '0;
  int            req_cnt = 0;
  int            resp_cnt = 0;
  bit            out_pend = 1'b0;
  logic [BW-1:0] out_pd = '0;
  int            done_cnt = 0;
  bit            prev_done = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Stand-in cipher: any fixed function of the counter block will do.
  function automatic logic [BW-1:0] ks_of(input logic [BW-1:0] cb);
    logic [31:0] h;
    if (ks_mode) return ks_const;
    h = cb[31:0] * 32'h9E37_79B9;
    return {cb[63:0] ^ 64'h0123_4567_89AB_CDEF, ~cb[127:64]} ^ {4{h}};
  endfunction

  // Keep the first 'tail' bytes (MSB first) of a block; tail 0 keeps all.
  function automatic logic [BW-1:0] ref_mask(input logic [BW-1:0] v, input int tail);
    logic [BW-1:0] ones;
    ones = '1;
    if (tail == 0) return v;
    return v & ~(ones >> (8 * tail));
  endfunction

  task automatic push_msg(input logic [BW-1:0] icb, input int n, input int tail);
    logic [BW-1:0] cb, d;
    for (int i = 0; i < n; i++) begin
      cb = {icb[127:32], icb[31:0] + 32'(i)};
      d  = data_mode ? data_const : {$urandom, $urandom, $urandom, $urandom};
      in_q.push_back(d);
      exp_req_q.push_back(cb);
      exp_out_q.push_back(ref_mask(d ^ ks_of(cb), (i == n - 1) ? tail : 0));
      exp_last_q.push_back(i == n - 1);
    end
  endtask

  task automatic issue_start(input logic [BW-1:0] icb, input int n, input int tail);
    @(posedge clk); #1;
    start = 1'b1; icb_in = icb; num_blocks = CW'(n); last_bytes = 4'(tail);
    @(posedge clk); #1;
    start = 1'b0; icb_in = {4{$urandom}}; num_blocks = CW'($urandom); last_bytes = 4'($urandom);
    check("busy_after_start", 128'(busy), 128'd1);
    check("in_ready_after_start", 128'(in_ready), 128'(n > 0));
  endtask

  // Cycles are counted from the start cycle (cycle 0); done in cycle 4N+1
  // means the 4N+2-th cycle when the start cycle is counted as the first.
  task automatic wait_done(input int n, input int exp_cycles);
    int cyc;
    bit any_hs;
    cyc = 1;
    any_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready || aes_req_valid || out_valid) any_hs = 1'b1;
      if (done || cyc >= 3000) break;
      @(posedge clk);
      cyc++;
    end
    check("done_seen", 128'(done), 128'd1);
    if (exp_cycles >= 0) check("done_latency", 128'(cyc), 128'(exp_cycles));
    if (n == 0) check("empty_no_handshake", 128'(any_hs), 128'd0);
    check("scoreboard_drained", 128'(exp_out_q.size() + exp_req_q.size() + in_q.size()), 128'd0);
    @(negedge clk);
    check("idle_after_done", 128'({busy, done}), 128'd0);
  endtask

  task automatic run_msg(input logic [BW-1:0] icb, input int n, input int tail, input int exp_cycles);
    push_msg(icb, n, tail);
    issue_start(icb, n, tail);
    wait_done(n, exp_cycles);
  endtask

  // Data-block source: holds in_valid/in_data until accepted
  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (in_fire) begin
        in_valid = 1'b0;
        void'(in_q.pop_front());
        in_fire = 1'b0;
      end
      if (!in_valid && in_q.size() > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        in_data  = in_q[0];
      end
      @(negedge clk);
      in_fire = in_valid && in_ready && !rst;
    end
  end

  // AES core model plus request monitor
  initial begin
    aes_req_ready  = 1'b0;
    aes_resp_valid = 1'b0;
    aes_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      aes_resp_valid = 1'b0;
      if (core_pend) begin
        if (core_dly == 0) begin
          aes_resp_valid = 1'b1;
          aes_resp_data  = ks_of(core_blk);
          core_pend = 1'b0;
          resp_cnt++;
        end else begin
          core_dly--;
        end
      end
      aes_req_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (rst) begin
        req_pend = 1'b0;
      end else begin
        if (req_pend) begin
          check("req_hold_valid", 128'(aes_req_valid), 128'd1);
          check("req_hold_block", aes_req_block, rq_blk);
        end
        if (aes_req_valid && aes_req_ready) begin
          if (exp_req_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL req_unexpected actual=%h required=none", aes_req_block);
          end else begin
            check("req_block", aes_req_block, exp_req_q.pop_front());
          end
          check("one_outstanding", 128'(core_pend), 128'd0);
          core_pend = 1'b1;
          core_blk  = aes_req_block;
          core_dly  = (resp_delay_cfg < 0) ? int'($urandom_range(0, 7)) : resp_delay_cfg;
          req_cnt++;
          req_pend = 1'b0;
        end else begin
          req_pend = aes_req_valid;
          rq_blk   = aes_req_block;
        end
      end
    end
  end

  // Result sink
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Result monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        out_pend = 1'b0;
      end else begin
        if (out_pend) begin
          check("out_hold_valid", 128'(out_valid), 128'd1);
          check("out_hold_data", out_data, out_pd);
        end
        if (out_valid && out_ready) begin
          if (exp_out_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL out_unexpected actual=%h required=none", out_data);
          end else begin
            check("out_data", out_data, exp_out_q.pop_front());
            check("out_last", 128'(out_last), 128'(exp_last_q.pop_front()));
          end
          out_pend = 1'b0;
        end else begin
          out_pend = out_valid;
          out_pd   = out_data;
        end
      end
    end
  end

  // Done pulse monitor
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("done_pulse_width", 128'(prev_done), 128'd0);
      end
      prev_done = done;
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int r0, d0, cyc;
    logic [BW-1:0] icb;
    int n;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 128'({busy, done, in_ready, aes_req_valid, out_valid, out_last}), 128'd0);
    check("reset_req_block", aes_req_block, '0);
    check("reset_out_data", out_data, '0);
    #1 rst = 1'b0;

    // Single block, zero-wait partners
    bp = 1'b0; resp_delay_cfg = 0;
    ks_mode = 1'b1; ks_const = {16{8'h0F}};
    data_mode = 1'b1; data_const = '1;
    run_msg(128'h1, 1, 0, 5);

    // Counter wrap across three blocks
    ks_mode = 1'b0; data_mode = 1'b0;
    icb = {$urandom, $urandom, $urandom, 32'hFFFF_FFFE};
    run_msg(icb, 3, 0, 13);

    // Empty message
    run_msg({4{$urandom}}, 0, 3, 1);

    // Tail masking on the final block only
    ks_mode = 1'b1; ks_const = '0;
    data_mode = 1'b1; data_const = {16{8'hAA}};
    run_msg({4{$urandom}}, 2, 5, 9);

    // Randomized backpressure and keystream delay
    ks_mode = 1'b0; data_mode = 1'b0;
    bp = 1'b1; resp_delay_cfg = -1;
    for (int m = 0; m < 8; m++) begin
      n = $urandom_range(0, 6);
      icb = {$urandom, $urandom, $urandom,
             ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : 32'($urandom)};
      run_msg(icb, n, $urandom_range(0, 15), -1);
    end

    // Reset while waiting for the keystream of block 2 of 4
    bp = 1'b0; resp_delay_cfg = 6;
    @(posedge clk); #1;
    r0 = req_cnt;
    icb = {4{$urandom}};
    push_msg(icb, 4, 0);
    issue_start(icb, 4, 0);
    cyc = 0;
    while (req_cnt < r0 + 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reset_reach_wait", 128'(req_cnt >= r0 + 2), 128'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_ctrl", 128'({busy, done, in_ready, aes_req_valid, out_valid, out_last}), 128'd0);
    check("midrst_req_block", aes_req_block, '0);
    check("midrst_out_data", out_data, '0);
    in_q.delete(); exp_req_q.delete(); exp_out_q.delete(); exp_last_q.delete();
    in_valid = 1'b0; in_fire = 1'b0;
    d0 = done_cnt;
    r0 = resp_cnt;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    check("late_resp_issued", 128'(resp_cnt > r0), 128'd1);
    check("no_done_after_abort", 128'(done_cnt), 128'(d0));
    check("idle_after_abort", 128'({busy, in_ready, aes_req_valid, out_valid}), 128'd0);

    // Fresh message after the abort
    resp_delay_cfg = 0;
    run_msg({4{$urandom}}, 3, 7, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
